id_hazard_ctrl: RTL and testbench

Pipeline interlock controller for the 16-bit five-stage core (IF, ID, EX, MEM, WB). Sits beside the ID-stage decoder, keeps a scoreboard of destination registers in flight in EX and MEM, and drives the pipeline-register enables, flush and bubble controls. It resolves RAW hazards, data-memory wait states and taken-branch flushes. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/id_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage interlock controller for the 16-bit five-stage core.
// Tracks destination registers in flight in EX and MEM and drives the PC,
// IF/ID and downstream pipeline-register enables, the IF/ID flush and the
// ID/EX bubble. It also keeps a saturating count of hazard-stall cycles.
// Build option: define HAZARD_FWD_EN when the EX/MEM->EX and MEM/WB->EX
// forwarding paths exist. Only a load in EX then forces a stall (load-use).
// Without it, any in-flight producer in EX or MEM interlocks.

module id_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_en,
    output logic [15:0] stall_cnt
);

    // Scoreboard entries {valid, dest, is_load} for EX and MEM, plus the counter.
    logic        ex_valid_q,  ex_valid_d;
    logic [2:0]  ex_dest_q,   ex_dest_d;
    logic        ex_load_q,   ex_load_d;
    logic        mem_valid_q, mem_valid_d;
    logic [2:0]  mem_dest_q,  mem_dest_d;
    logic        mem_load_q,  mem_load_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Fields of the instruction sitting in IF/ID.
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        reads_rs1;
    logic        reads_rs2;
    logic        reads_rd;
    logic        writes_rd;
    logic        is_load;
    logic        hazard;

    // The rs2 low bits are immediate/unused fields. The MEM load flag is kept
    // for visibility only, because the hazard check never consults it.
    logic        unused_bits;
    assign unused_bits = ^{id_instr[2:0], mem_load_q};

    assign opcode = id_instr[15:12];
    assign rd     = id_instr[11:9];
    assign rs1    = id_instr[8:6];
    assign rs2    = id_instr[5:3];

    // Decode which register fields the instruction reads and whether it writes rd.
    always_comb begin
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        reads_rd  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                writes_rd = 1'b1;
            end
            4'd9: begin
                reads_rs1 = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            4'd10: begin
                reads_rs1 = 1'b1;
                reads_rd  = 1'b1;
            end
            4'd11: begin
                reads_rs1 = 1'b1;
            end
            default: begin
                reads_rs1 = 1'b0;
            end
        endcase
    end

    // RAW check of every read source against the in-flight destinations.
    // r0 is hardwired to zero, so a zero source never matches anything.
    always_comb begin
        logic [2:0] src [3];
        logic       rd_en [3];
        hazard   = 1'b0;
        src[0]   = rs1;
        src[1]   = rs2;
        src[2]   = rd;
        rd_en[0] = reads_rs1;
        rd_en[1] = reads_rs2;
        rd_en[2] = reads_rd;
        for (int i = 0; i < 3; i++) begin
            if (id_valid && rd_en[i] && (src[i] != 3'd0)) begin
`ifdef HAZARD_FWD_EN
                if (ex_valid_q && ex_load_q && (ex_dest_q == src[i]))
                    hazard = 1'b1;
`else
                if (ex_valid_q && (ex_dest_q == src[i]))
                    hazard = 1'b1;
                if (mem_valid_q && (mem_dest_q == src[i]))
                    hazard = 1'b1;
`endif
            end
        end
    end

    // Control priority (rst, mem_busy, br_taken, hazard, run) and next scoreboard/counter.
    always_comb begin
        logic bubble;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b1;
        bubble      = 1'b0;
        ex_valid_d  = ex_valid_q;
        ex_dest_d   = ex_dest_q;
        ex_load_d   = ex_load_q;
        mem_valid_d = mem_valid_q;
        mem_dest_d  = mem_dest_q;
        mem_load_d  = mem_load_q;
        stall_cnt_d = stall_cnt_q;

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            pipe_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            pipe_en     = 1'b0;
        end else begin
            if (br_taken) begin
                // The stalled instruction is being flushed, so no stall is counted.
                ifid_flush = 1'b1;
                bubble     = 1'b1;
            end else if (hazard) begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                bubble  = 1'b1;
                if (stall_cnt_q != 16'hFFFF)
                    stall_cnt_d = stall_cnt_q + 16'd1;
            end
            idex_bubble = bubble;

            mem_valid_d = ex_valid_q;
            mem_dest_d  = ex_dest_q;
            mem_load_d  = ex_load_q;
            if (bubble) begin
                ex_valid_d = 1'b0;
                ex_dest_d  = 3'd0;
                ex_load_d  = 1'b0;
            end else begin
                ex_valid_d = id_valid && writes_rd && (rd != 3'd0);
                ex_dest_d  = rd;
                ex_load_d  = is_load;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_dest_q   <= 3'd0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_dest_q  <= 3'd0;
            mem_load_q  <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_dest_q   <= ex_dest_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_dest_q  <= mem_dest_d;
            mem_load_q  <= mem_load_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl. An instruction table carries the
// expected stall count of each entry for both build options. Hand-written
// sequences cover reset, branch-over-hazard, memory freeze and saturation.
// Every expected cycle is pushed to a queue and popped when the outputs are sampled.

module tb_id_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] id_instr;
    logic        id_valid;
    logic        br_taken;
    logic        mem_busy;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_en;
    logic [15:0] stall_cnt;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en}
    localparam logic [4:0] C_RST = 5'b00110;
    localparam logic [4:0] C_FRZ = 5'b00000;
    localparam logic [4:0] C_BR  = 5'b11111;
    localparam logic [4:0] C_STL = 5'b00011;
    localparam logic [4:0] C_RUN = 5'b11001;
    localparam logic [15:0] NOP  = 16'h0000;

    typedef struct {
        logic [4:0]  ctrl;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic        valid;
        int          st_nf;
        int          st_fw;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tbl[$];
    int          n_vec;
    int          n_err;
    logic [15:0] exp_cnt;

    id_hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .br_taken    (br_taken),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .pipe_en     (pipe_en),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc(int op, int d, int s1, int s2);
        logic [15:0] w;
        w = {op[3:0], d[2:0], s1[2:0], s2[2:0], 3'b000};
        return w;
    endfunction

    task automatic drive(logic [15:0] instr, logic v, logic br, logic busy, logic r);
        id_instr = instr;
        id_valid = v;
        br_taken = br;
        mem_busy = busy;
        rst      = r;
    endtask

    // Push the expectation for this cycle, sample and compare, then advance one edge.
    task automatic cyc(string nm, logic [4:0] ctrl);
        exp_t e;
        exp_t got;
        logic [4:0] act;
        e.ctrl = ctrl;
        e.cnt  = exp_cnt;
        e.name = nm;
        sb_q.push_back(e);
        #2;
        got = sb_q.pop_front();
        act = {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en};
        n_vec++;
        if (act !== got.ctrl || stall_cnt !== got.cnt) begin
            n_err++;
            $display("FAIL %s: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                     got.name, act, stall_cnt, got.ctrl, got.cnt);
        end
        @(posedge clk);
        #1;
        if (rst)
            exp_cnt = 16'd0;
        else if (ctrl == C_STL && exp_cnt != 16'hFFFF)
            exp_cnt = exp_cnt + 16'd1;
    endtask

    // Present one instruction, hold it through its expected stall cycles, then let it issue.
    task automatic issue(string nm, logic [15:0] instr, logic v, int n);
        drive(instr, v, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < n; s++) cyc(nm, C_STL);
        cyc(nm, C_RUN);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 16'd0;

        // instr, valid, stalls without forwarding, stalls with forwarding
        tbl.push_back('{enc(1, 1, 2, 3), 1'b1, 0, 0});  // r1 <- r2,r3
        tbl.push_back('{enc(2, 4, 1, 5), 1'b1, 2, 0});  // ALU use at distance 1
        tbl.push_back('{enc(1, 0, 2, 3), 1'b1, 0, 0});  // writes r0
        tbl.push_back('{enc(1, 4, 0, 0), 1'b1, 0, 0});  // reads r0 only
        tbl.push_back('{enc(3, 5, 1, 1), 1'b1, 0, 0});
        tbl.push_back('{NOP,             1'b1, 0, 0});
        tbl.push_back('{enc(4, 6, 5, 0), 1'b1, 1, 0});  // distance 2
        tbl.push_back('{NOP,             1'b1, 0, 0});
        tbl.push_back('{NOP,             1'b1, 0, 0});
        tbl.push_back('{enc(1, 7, 6, 6), 1'b1, 0, 0});  // distance 3
        tbl.push_back('{enc(9, 2, 1, 0), 1'b1, 0, 0});  // LD r2
        tbl.push_back('{enc(1, 3, 2, 2), 1'b1, 2, 1});  // load-use
        tbl.push_back('{enc(10, 3, 0, 0), 1'b1, 2, 0}); // ST reads rd
        tbl.push_back('{enc(12, 3, 3, 3), 1'b1, 0, 0}); // 1100 reads nothing
        tbl.push_back('{enc(1, 5, 0, 0), 1'b1, 0, 0});
        tbl.push_back('{enc(11, 0, 5, 0), 1'b1, 2, 0}); // BZ reads rs1
        tbl.push_back('{enc(9, 6, 0, 0), 1'b1, 0, 0});  // LD r6
        tbl.push_back('{NOP,             1'b1, 0, 0});
        tbl.push_back('{enc(2, 7, 0, 6), 1'b1, 1, 0});  // load at distance 2
        tbl.push_back('{enc(1, 7, 7, 7), 1'b0, 0, 0});  // not valid
        tbl.push_back('{enc(1, 1, 7, 0), 1'b1, 1, 0});  // r7 producer at distance 2

        // Reset: first edge brings state out of X, second cycle checks values.
        drive(NOP, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        cyc("reset", C_RST);

        foreach (tbl[i])
            issue($sformatf("tbl%0d", i), tbl[i].instr, tbl[i].valid,
                  FWD ? tbl[i].st_fw : tbl[i].st_nf);
        issue("drain", NOP, 1'b1, 0);
        issue("drain", NOP, 1'b1, 0);

        // Branch taken with a hazard pending: flush wins, counter holds.
        issue("br_prod", enc(9, 1, 2, 3), 1'b1, 0);
        drive(enc(2, 4, 1, 5), 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("br_over_hazard", C_BR);
        issue("br_after", NOP, 1'b1, 0);
        issue("br_after", NOP, 1'b1, 0);

        // Memory freeze before and in the middle of a load-use stall.
        issue("frz_prod", enc(9, 2, 0, 0), 1'b1, 0);
        drive(enc(1, 3, 2, 2), 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc("freeze_pre", C_FRZ);
        drive(enc(1, 3, 2, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("freeze_stall1", C_STL);
        drive(enc(1, 3, 2, 2), 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc("freeze_mid", C_FRZ);
        issue("freeze_rest", enc(1, 3, 2, 2), 1'b1, FWD ? 0 : 1);

        // Saturation: preload the counter, then a load chain of dependent stalls.
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        @(posedge clk);
        #1;
        exp_cnt = 16'hFFFE;
        issue("sat_ld1", enc(9, 1, 0, 0), 1'b1, 0);
        issue("sat_ld2", enc(9, 2, 1, 0), 1'b1, FWD ? 1 : 2);
        issue("sat_ld3", enc(9, 3, 2, 0), 1'b1, FWD ? 1 : 2);
        issue("sat_ld4", enc(9, 4, 3, 0), 1'b1, FWD ? 1 : 2);

        // Reset while a load-use stall is pending, then the same consumer sees no hazard.
        drive(enc(1, 5, 4, 4), 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("reset_mid_stall", C_RST);
        drive(enc(1, 5, 4, 4), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("after_reset", C_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
